// File: rtl/lock_pkg.sv
// lock_pkg: state encoding, digit constants and key decoding shared by the combination lock
package lock_pkg;
  localparam int DIGIT_W = 2;
  localparam int NUM_DIGIT_KEYS = 4;
  typedef logic [2:0] lock_state_t;
  localparam lock_state_t IDLE    = 3'd0;
  localparam lock_state_t ENTRY   = 3'd1;
  localparam lock_state_t CHECK   = 3'd2;
  localparam lock_state_t FAIL    = 3'd3;
  localparam lock_state_t OPEN    = 3'd4;
  localparam lock_state_t LOCKOUT = 3'd5;
  function automatic logic [DIGIT_W-1:0] key_digit(input logic [NUM_DIGIT_KEYS-1:0] k);
    key_digit = '0;
    for (int i = 0; i < NUM_DIGIT_KEYS; i++)
      if (k[i]) key_digit = DIGIT_W'(i);
  endfunction
endpackage

// File: rtl/lock_code_fsm_if.sv
// lock_code_fsm_if: key pulses in, lock status out
interface lock_code_fsm_if;
  import lock_pkg::*;
  logic [NUM_DIGIT_KEYS-1:0] key_flag;
  logic enter_flag;
  logic clear_flag;
  logic unlocked;
  logic err;
  logic alarm;
  logic [2:0] digit_cnt;
  modport master(output key_flag, enter_flag, clear_flag, input unlocked, err, alarm, digit_cnt);
  modport slave(input key_flag, enter_flag, clear_flag, output unlocked, err, alarm, digit_cnt);
endinterface

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter; expire marks the cycle whose edge brings the count to 0
module lock_timer #(
  parameter int W = 20
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) cnt <= '0;
    else cnt <= load ? load_val : cnt != '0 ? cnt - W'(1) : cnt;
  assign expire = cnt == W'(1);
endmodule

// File: rtl/lock_code_fsm.sv
// lock_code_fsm: combination-lock controller; define LOCK_CHANGE_CODE_EN to allow re-coding while open
module lock_code_fsm import lock_pkg::*; #(
  parameter int CODE_LEN = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 8'hE4,
  parameter int MAX_FAIL = 3,
  parameter int OPEN_CYCLES = 1000,
  parameter int LOCK_CYCLES = 5000,
  parameter int IDLE_TIMEOUT = 2000,
  parameter int TIMER_W = 20
) (
  input logic Clk,
  input logic Rst_n,
  lock_code_fsm_if.slave bus
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int IW = $clog2(CODE_LEN);
  localparam logic [2:0] FULL = 3'(CODE_LEN);
  lock_state_t st, nxt;
  logic [CODE_LEN-1:0][DIGIT_W-1:0] code_buf, code_reg;
  logic [2:0] cnt;
  logic [FW-1:0] fail_cnt;
  logic [TIMER_W-1:0] ld_val;
  logic [DIGIT_W-1:0] dig;
  logic ovf, unlocked, err, alarm, tmr_exp, ld, dv, clr, ent, key_any, acc, open_dig, match, wipe;
  assign clr = bus.clear_flag;
  assign ent = bus.enter_flag & ~clr;
  assign dv = $onehot(bus.key_flag) & ~clr & ~ent;
  assign dig = key_digit(bus.key_flag);
  assign key_any = |{bus.key_flag, bus.enter_flag, clr};
  assign match = cnt == FULL && !ovf && code_buf == code_reg;
`ifdef LOCK_CHANGE_CODE_EN
  assign open_dig = st == OPEN && dv;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) code_reg <= DEFAULT_CODE;
    else if (st == OPEN && ent && cnt == FULL && !ovf) code_reg <= code_buf;
`else
  assign open_dig = 1'b0;
  assign code_reg = DEFAULT_CODE;
`endif
  assign acc = dv && (st == IDLE || st == ENTRY || open_dig);
  assign wipe = st == CHECK || ((st == ENTRY || st == OPEN) && nxt == IDLE);
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = dv ? ENTRY : IDLE;
      ENTRY:   nxt = clr ? IDLE : ent ? CHECK : (tmr_exp && !key_any) ? IDLE : ENTRY;
      CHECK:   nxt = match ? OPEN : (fail_cnt + FW'(1) == FW'(MAX_FAIL)) ? LOCKOUT : FAIL;
      FAIL:    nxt = IDLE;
      OPEN:    nxt = (ent || (tmr_exp && !open_dig)) ? IDLE : OPEN;
      LOCKOUT: nxt = tmr_exp ? IDLE : LOCKOUT;
      default: nxt = IDLE;
    endcase
  end
  assign ld = (st == IDLE && dv) || (st == ENTRY && key_any) || (st == CHECK && nxt != FAIL) || open_dig;
  assign ld_val = st == CHECK ? (match ? TIMER_W'(OPEN_CYCLES) : TIMER_W'(LOCK_CYCLES))
                : st == OPEN ? TIMER_W'(OPEN_CYCLES) : TIMER_W'(IDLE_TIMEOUT);
  lock_timer #(.W(TIMER_W)) u_timer (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .load(ld),
    .load_val(ld_val),
    .expire(tmr_exp)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      st <= IDLE;
      {unlocked, err, alarm, ovf} <= '0;
      code_buf <= '0;
      cnt <= '0;
      fail_cnt <= '0;
    end else begin
      st <= nxt;
      unlocked <= nxt == OPEN;
      err <= nxt == FAIL;
      alarm <= nxt == LOCKOUT;
      if (wipe) begin
        code_buf <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (acc) begin
        if (cnt == FULL) ovf <= 1'b1;
        else begin
          code_buf[cnt[IW-1:0]] <= dig;
          cnt <= cnt + 3'd1;
        end
      end
      if (st == CHECK) fail_cnt <= match ? '0 : fail_cnt + FW'(1);
      else if (st == LOCKOUT && tmr_exp) fail_cnt <= '0;
    end
  assign bus.unlocked = unlocked;
  assign bus.err = err;
  assign bus.alarm = alarm;
  assign bus.digit_cnt = cnt;
endmodule

// File: tb/tb_lock_code_fsm.sv
// tb_lock_code_fsm: scoreboard bench for the lock; the code-change scenario runs when LOCK_CHANGE_CODE_EN is defined
module tb_lock_code_fsm;
  typedef struct {
    string n;
    logic [5:0] v;
  } exp_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  exp_t sb[$];
  lock_code_fsm_if bus();
  lock_code_fsm dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;

  function automatic logic [5:0] obs();
    return {bus.unlocked, bus.err, bus.alarm, bus.digit_cnt};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
      cyc_no++;
    end
  endtask

  task automatic pulse(input logic [3:0] k, input logic e = 1'b0, input logic c = 1'b0);
    bus.key_flag = k;
    bus.enter_flag = e;
    bus.clear_flag = c;
    cyc();
    bus.key_flag = '0;
    bus.enter_flag = 1'b0;
    bus.clear_flag = 1'b0;
  endtask

  task automatic code_in(input logic [7:0] c);
    for (int i = 0; i < 4; i++) pulse(4'b0001 << c[2*i +: 2]);
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    cyc();
    Rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('{"reset_outputs", 6'b000_000});
    Rst_n = 1'b0;
    cyc(2);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    total++;
    if (dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL reset_fail_cnt: got %0d want 0", dut.fail_cnt); end
    Rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_correct_code();
    exp_t e;
    code_in(8'hE4);
    sb.push_back('{"cnt_full", 6'b000_100});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
    sb.push_back('{"open_at_k2", 6'b100_000});
    cyc();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    sb.push_back('{"open_last_cycle", 6'b100_000});
    cyc(999);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    sb.push_back('{"auto_relock", 6'b000_000});
    cyc();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    total++;
    if (dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL open_fail_cnt: got %0d want 0", dut.fail_cnt); end
  endtask

  task automatic test_wrong_code();
    exp_t e;
    code_in(8'hA4);
    pulse(4'b0, 1'b1);
    sb.push_back('{"err_pulse", 6'b010_000});
    cyc();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    sb.push_back('{"err_one_cycle", 6'b000_000});
    cyc();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    total++;
    if (dut.fail_cnt !== 2'd1) begin bad++; $display("FAIL wrong_fail_cnt: got %0d want 1", dut.fail_cnt); end
  endtask

  task automatic test_lockout();
    exp_t e;
    int t0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      code_in(8'hA4);
      pulse(4'b0, 1'b1);
      cyc();
      if (i < 2) cyc();
    end
    sb.push_back('{"alarm_on", 6'b001_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    t0 = cyc_no;
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    sb.push_back('{"lockout_ignores_keys", 6'b001_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc(t0 + 4999 - cyc_no);
    sb.push_back('{"alarm_last_cycle", 6'b001_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    sb.push_back('{"alarm_off", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    total++;
    if (dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL lockout_fail_cnt: got %0d want 0", dut.fail_cnt); end
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"open_after_lockout", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
    sb.push_back('{"enter_relocks", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
  endtask

  task automatic test_overflow_clear_multikey();
    exp_t e;
    code_in(8'hE4);
    pulse(4'b0001);
    sb.push_back('{"overflow_cnt_sat", 6'b000_100});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"overflow_err", 6'b010_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    pulse(4'b0001);
    pulse(4'b0010);
    sb.push_back('{"cnt_two", 6'b000_010});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b0, 1'b1);
    sb.push_back('{"clear_cnt", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0001);
    pulse(4'b0011);
    sb.push_back('{"multikey_ignored", 6'b000_001});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0100, 1'b0, 1'b1);
    sb.push_back('{"clear_beats_digit", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0001, 1'b1);
    sb.push_back('{"enter_beats_digit_idle", 6'b000_000});
    cyc();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
  endtask

  task automatic test_timeout();
    exp_t e;
    pulse(4'b0001);
    pulse(4'b0010);
    cyc(1999);
    sb.push_back('{"timeout_hold", 6'b000_010});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    sb.push_back('{"timeout_clear", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0100);
    sb.push_back('{"idle_after_timeout", 6'b000_001});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    pulse(4'b0, 1'b1);
    sb.push_back('{"b2b_relock", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    code_in(8'h24);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"b2b_err", 6'b010_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"b2b_open", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
  endtask

`ifdef LOCK_CHANGE_CODE_EN
  task automatic test_code_change();
    exp_t e;
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    code_in(8'hFF);
    sb.push_back('{"open_collects_digits", 6'b100_100});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
    sb.push_back('{"new_code_relock", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"old_code_err", 6'b010_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    code_in(8'hFF);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"new_code_opens", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
    apply_reset();
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"default_after_reset", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    pulse(4'b0, 1'b1);
  endtask
`else
  task automatic test_open_digits();
    exp_t e;
    int t0;
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    t0 = cyc_no;
    pulse(4'b1000);
    pulse(4'b0100);
    sb.push_back('{"open_ignores_digits", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc(t0 + 999 - cyc_no);
    sb.push_back('{"open_timer_kept", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    sb.push_back('{"open_timer_expired", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    code_in(8'hE4);
    pulse(4'b0, 1'b1);
    cyc();
    sb.push_back('{"open_before_reset", 6'b100_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    #2;
    Rst_n = 1'b0;
    #1;
    sb.push_back('{"async_reset_outputs", 6'b000_000});
    e = sb.pop_front(); total++;
    if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, obs(), e.v); end
    cyc();
    Rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    bus.key_flag = '0;
    bus.enter_flag = 1'b0;
    bus.clear_flag = 1'b0;
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_overflow_clear_multikey();
    test_timeout();
    test_back_to_back();
`ifdef LOCK_CHANGE_CODE_EN
    test_code_change();
`else
    test_open_digits();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_code_fsm.md
# lock_code_fsm

Combination-lock controller that consumes the single-cycle debounced key pulses produced by the key filter instances (four digit keys, one enter key, one clear key). It assembles a fixed-length digit code, compares it against the stored code and drives the unlock, error and alarm outputs. A failed-attempt counter with timed lockout protects the lock, and an auto-relock timer closes it again.

## Interface
- CODE_LEN, 4: digits per code; each digit is 2 bits, so 0..3.
- DEFAULT_CODE, 8'hE4: reset code; the first digit is in bits [1:0]. The default is the sequence 0,1,2,3.
- MAX_FAIL, 3: consecutive failed checks that trigger lockout.
- OPEN_CYCLES, 1000: cycles the lock stays open before auto-relock.
- LOCK_CYCLES, 5000: lockout duration in cycles.
- IDLE_TIMEOUT, 2000: cycles with no key during entry before the entry is abandoned.
- TIMER_W, 20: width of the shared timer. It must hold the largest of the three cycle parameters.
- Clk  in  1  clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- key_flag  in  4  one-cycle digit pulses; bit i means digit i.
- enter_flag  in  1  one-cycle enter pulse.
- clear_flag  in  1  one-cycle clear pulse.
- unlocked  out  1  level, high while in OPEN.
- err  out  1  one-cycle pulse on a failed check.
- alarm  out  1  level, high while in LOCKOUT.
- digit_cnt  out  3  number of digits entered so far, saturating at CODE_LEN.

## Operation
- **Input priority** within one cycle: clear_flag, then enter_flag, then digits.
- **Digit validity:** a key_flag pattern with more than one bit set is ignored entirely.
- **IDLE:**
  - A valid digit stores into slot 0, sets digit_cnt=1 and moves to ENTRY.
  - Enter and clear are ignored.
- **ENTRY:**
  - Digit with digit_cnt<CODE_LEN: store into slot digit_cnt and increment digit_cnt.
  - Digit with digit_cnt==CODE_LEN: set the overflow flag; the buffer is unchanged.
  - Clear: reset the buffer, digit_cnt and overflow, then go to IDLE.
  - Enter: go to CHECK.
  - IDLE_TIMEOUT cycles with no key pulse: behave exactly as clear. The timer is reloaded on every key pulse.
- **CHECK** (one cycle):
  - Match condition: digit_cnt==CODE_LEN, overflow=0, and buffer==code_reg.
  - Match: clear fail_cnt, go to OPEN, load the timer with OPEN_CYCLES.
  - Mismatch: increment fail_cnt. If the new value equals MAX_FAIL, go to LOCKOUT and load the timer with LOCK_CYCLES; otherwise go to FAIL.
  - The buffer, digit_cnt and overflow are cleared on leaving CHECK.
- **FAIL:** err=1 for exactly one cycle, then IDLE.
- **OPEN:**
  - unlocked=1.
  - Timer expiry or an enter pulse returns to IDLE.
  - Digits are ignored unless LOCK_CHANGE_CODE_EN is defined.
- **LOCKOUT:**
  - alarm=1 and all keys are ignored.
  - Timer expiry clears fail_cnt and returns to IDLE.
- **Timer:** counts down to 0. Expiry is the cycle in which the count reaches 0.
- **Arithmetic:**
  - fail_cnt is $clog2(MAX_FAIL+1) bits and never exceeds MAX_FAIL.
  - digit_cnt saturates at CODE_LEN.
- **Reset**, including mid-operation:
  - State goes to IDLE; every output is 0.
  - fail_cnt, buffer and overflow are cleared; the timer is 0.
  - code_reg returns to DEFAULT_CODE.

## Timing
- All outputs are registered and depend only on the state (Moore).
- A digit pulse in cycle k is reflected in digit_cnt in cycle k+1.
- An enter pulse in cycle k gives CHECK in cycle k+1. The result appears in cycle k+2: unlocked=1, err=1 or alarm=1.
- unlocked stays high for OPEN_CYCLES cycles and falls at k+2+OPEN_CYCLES if no enter arrives.
- alarm stays high for LOCK_CYCLES cycles.

## Configuration
- **With LOCK_CHANGE_CODE_EN defined:**
  - In OPEN, digits accumulate into the buffer, following the same overflow rules as ENTRY.
  - Enter with exactly CODE_LEN digits and no overflow writes code_reg, then relocks to IDLE.
  - Enter with any other buffer contents relocks without changing code_reg.
  - Every digit in OPEN reloads the timer with OPEN_CYCLES.
- **Without it:**
  - code_reg is the constant DEFAULT_CODE.
  - Digits in OPEN are ignored and do not affect the timer.

## Structure
- Shared package lock_pkg holds:
  - the state enumeration: IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT;
  - the digit width constant DIGIT_W=2;
  - the key-count constant NUM_DIGIT_KEYS=4.
- One sub-module, lock_timer, provides a loadable down-counter with an expire output. It is shared by the timeout, open and lockout timing.

## Test plan
- **Correct code:** digits 0,1,2,3 then enter at cycle k -> unlocked=1 at k+2. Without further input, unlocked=0 at k+2+1000 and fail_cnt=0.
- **Wrong code:** digits 0,1,2,2 then enter -> err pulses for one cycle at k+2, unlocked stays 0, fail_cnt=1.
- **Lockout:** three wrong codes -> alarm=1 for 5000 cycles. During lockout, a correct code is ignored. After lockout the correct code opens the lock.
- **Overflow, clear and multi-key:**
  - Digits 0,1,2,3,0 then enter -> err.
  - Clear after 0,1 -> digit_cnt=0.
  - key_flag=4'b0011 -> digit_cnt unchanged.
- **Timeout and reset:**
  - Digits 0,1, then 2000 idle cycles -> digit_cnt=0 and state IDLE.
  - Rst_n low while unlocked -> all outputs 0 immediately.
- **Code change** (LOCK_CHANGE_CODE_EN defined): open, enter 3,3,3,3, enter. Then 0,1,2,3 -> err; 3,3,3,3 -> unlocked. After reset, 0,1,2,3 opens again.
